// File: rtl/rr_mux4_arbiter.sv
// rr_mux4_arbiter: round-robin arbiter sharing one 4:1 select path among four
// requesters and presenting the granted nibble, zero-extended, on a registered
// valid/ready output slot.
//   clk        rising-edge system clock
//   rst_n      asynchronous active-low reset
//   req[3:0]   per-requester level valid
//   din0..din3 requester data (DW bits each)
//   ack[3:0]   combinational one-hot grant; din of the acked requester is taken at this edge
//   sel[1:0]   index of the requester whose data sits in the output slot
//   out_valid  output slot occupied
//   out_data   zero-extended captured data (OW bits)
//   out_ready  consumer accepts out_data when out_valid & out_ready
//   busy       mirror of out_valid
module rr_mux4_arbiter #(
    parameter int DW = 4,
    parameter int OW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    req,
    input  logic [DW-1:0] din0,
    input  logic [DW-1:0] din1,
    input  logic [DW-1:0] din2,
    input  logic [DW-1:0] din3,
    output logic [3:0]    ack,
    output logic [1:0]    sel,
    output logic          out_valid,
    output logic [OW-1:0] out_data,
    input  logic          out_ready,
    output logic          busy
);
    localparam logic IDLE = 1'b0;
    localparam logic HOLD = 1'b1;

    logic          state;
    logic [1:0]    ptr;
    logic [1:0]    win;
    logic [DW-1:0] din_w;
    logic          can_take;
    logic          take;

    // Scan from the farthest slot back to ptr so the nearest pending requester wins.
    always_comb begin
        win = ptr;
        for (int k = 3; k >= 0; k--)
            if (req[ptr + 2'(k)]) win = ptr + 2'(k);
    end

    assign din_w     = win == 2'd0 ? din0 : win == 2'd1 ? din1 : win == 2'd2 ? din2 : din3;
    assign can_take  = (state == IDLE) | out_ready;
    assign take      = can_take & |req;
    // rst_n gating keeps ack low while reset is asserted even if req is high.
    assign ack       = (rst_n & take) ? 4'(4'b0001 << win) : 4'b0000;
    assign out_valid = (state == HOLD);
    assign busy      = out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= 2'd0;
            sel      <= 2'd0;
            out_data <= '0;
        end else if (take) begin
            state    <= HOLD;
            ptr      <= win + 2'd1;
            sel      <= win;
            out_data <= OW'(din_w);
        end else if (state == HOLD && out_ready) begin
            state    <= IDLE;
        end
    end
endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// tb_rr_mux4_arbiter: directed self-checking bench with a cycle-level reference model.
module tb_rr_mux4_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0;
    logic [3:0] din [4];
    logic       out_ready = 1'b0;
    logic [3:0] ack;
    logic [1:0] sel;
    logic       out_valid;
    logic [7:0] out_data;
    logic       busy;

    int npass = 0;
    int ntot  = 0;
    bit chk_en = 1'b0;

    logic       m_valid;
    logic [7:0] m_data;
    logic [1:0] m_sel;
    int         m_ptr;

    rr_mux4_arbiter #(.DW(4), .OW(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .din0(din[0]), .din1(din[1]), .din2(din[2]), .din3(din[3]),
        .ack(ack), .sel(sel), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int winner(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return 0;
    endfunction

    function automatic logic model_take();
        return (!m_valid || out_ready) && (req != 4'b0);
    endfunction

    function automatic logic [3:0] model_ack();
        return (rst_n && model_take()) ? 4'(1 << winner(req, m_ptr)) : 4'b0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= 8'h00;
            m_sel   <= 2'd0;
            m_ptr   <= 0;
        end else if (model_take()) begin
            m_valid <= 1'b1;
            m_data  <= 8'(din[winner(req, m_ptr)]);
            m_sel   <= 2'(winner(req, m_ptr));
            m_ptr   <= (winner(req, m_ptr) + 1) % 4;
        end else if (m_valid && out_ready) begin
            m_valid <= 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_ack", 32'(ack), 32'(model_ack()));
            chk("model_valid", 32'(out_valid), 32'(m_valid));
            chk("model_busy", 32'(busy), 32'(m_valid));
            chk("model_data", 32'(out_data), 32'(m_data));
            chk("model_sel", 32'(sel), 32'(m_sel));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        din[0] = 4'h0; din[1] = 4'h0; din[2] = 4'h0; din[3] = 4'h0;
        // T1: reset holds everything low even with requests pending
        #7 req = 4'b1111;
        #1;
        chk("t1_valid", 32'(out_valid), 32'h0);
        chk("t1_data", 32'(out_data), 32'h0);
        chk("t1_sel", 32'(sel), 32'h0);
        chk("t1_ack", 32'(ack), 32'h0);
        #14 req = 4'b0;
        rst_n = 1'b1;
        chk_en = 1'b1;
        // T2: single requester
        tick();
        req = 4'b0100; din[2] = 4'hA; out_ready = 1'b1;
        #1 chk("t2_ack", 32'(ack), 32'h4);
        tick();
        req = 4'b0;
        chk("t2_valid", 32'(out_valid), 32'h1);
        chk("t2_sel", 32'(sel), 32'h2);
        chk("t2_data", 32'(out_data), 32'h0A);
        tick();
        chk("t2_drain_valid", 32'(out_valid), 32'h0);
        chk("t2_drain_data", 32'(out_data), 32'h0A);
        // T3: fairness from reset
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) din[i] = 4'(i + 1);
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_valid", 32'(out_valid), 32'h1);
            chk("t3_data", 32'(out_data), 32'((i % 4) + 1));
        end
        // T4: backpressure holds the slot stable
        din[1] = 4'h5;
        tick();
        chk("t4_data", 32'(out_data), 32'h05);
        chk("t4_sel", 32'(sel), 32'h1);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_hold_ack", 32'(ack), 32'h0);
            chk("t4_hold_data", 32'(out_data), 32'h05);
            chk("t4_hold_sel", 32'(sel), 32'h1);
        end
        out_ready = 1'b1;
        #1 chk("t4_release_ack", 32'(ack), 32'h4);
        // T5: pointer wrap
        tick();
        req = 4'b1000;
        tick();
        chk("t5_sel3", 32'(sel), 32'h3);
        req = 4'b1001;
        tick();
        chk("t5_sel0", 32'(sel), 32'h0);
        chk("t5_data0", 32'(out_data), 32'h01);
        tick();
        chk("t5_sel3b", 32'(sel), 32'h3);
        chk("t5_data3", 32'(out_data), 32'h04);
        // T6: reset while holding
        out_ready = 1'b0;
        req = 4'b0;
        tick();
        chk("t6_pre_valid", 32'(out_valid), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_valid", 32'(out_valid), 32'h0);
        chk("t6_data", 32'(out_data), 32'h0);
        chk("t6_sel", 32'(sel), 32'h0);
        #1 rst_n = 1'b1;
        req = 4'b1010; out_ready = 1'b1;
        #1 chk("t6_ack", 32'(ack), 32'h2);
        tick();
        chk("t6_sel_after", 32'(sel), 32'h1);
        chk("t6_data_after", 32'(out_data), 32'h05);
        tick();
        chk("t6_next_sel", 32'(sel), 32'h3);
        req = 4'b0;
        tick();
        tick();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
